johnson_led_ctrl: RTL and testbench

//  Drives an LED bank with a Johnson (twisted-ring) pattern. Sits directly downstream of the
//  key debouncers: consumes their toggling enable levels (one for run/pause, one for direction).

---
 rtl/johnson_led_ctrl_pkg.sv | 17 +
 rtl/johnson_led_ctrl_if.sv | 22 ++
 rtl/johnson_led_ctrl_tick_gen.sv | 27 ++
 rtl/johnson_led_ctrl.sv | 88 ++++++++
 tb/tb_johnson_led_ctrl.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/johnson_led_ctrl_pkg.sv
// Shared encodings for the Johnson LED controller: FSM states and shift direction.
package johnson_pkg;

    // Controller states; the spare code 2'd3 is treated as a fault and recovers to S_IDLE.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    // Pattern shift direction as presented on dir_o.
    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

endpackage

// File: rtl/johnson_led_ctrl_if.sv
// Key-level inputs and LED-side outputs of the Johnson LED controller.
interface johnson_led_ctrl_if #(
    parameter int LED_W = 4
);
    logic             run_en;     // debounced toggle level: 1 = run, 0 = pause
    logic             dir_en;     // debounced toggle level: each transition reverses direction
    logic [LED_W-1:0] led;        // Johnson pattern, active-high
    logic             step_tick;  // 1-cycle pulse in the cycle led takes a new value
    logic             dir_o;      // 0 = shift left, 1 = shift right

    // Key side drives the enables and observes the pattern.
    modport master (
        output run_en, dir_en,
        input  led, step_tick, dir_o
    );

    // Controller side consumes the enables and drives the pattern.
    modport slave (
        input  run_en, dir_en,
        output led, step_tick, dir_o
    );
endinterface

// File: rtl/johnson_led_ctrl_tick_gen.sv
// Prescaler: counts enabled cycles and pulses tick on the cycle the count wraps.
module tick_gen #(
    parameter int TICK_CNT = 25_000_000,
    parameter int CNT_W    = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CNT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Tick is combinational so the caller can register its effect on the same edge the count wraps.
    assign tick = en && (cnt_q == LAST);

    // Count enabled cycles, wrap to zero at LAST; hold the value while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/johnson_led_ctrl.sv
// Johnson LED controller: run/pause FSM, direction toggle from key edges,
// prescaled stepping of a twisted-ring register with illegal-code recovery.
module johnson_led_ctrl
    import johnson_pkg::*;
#(
    parameter int LED_W    = 4,
    parameter int TICK_CNT = 25_000_000,
    parameter int CNT_W    = 25
) (
    input  logic              clk,
    input  logic              rst_n,
    johnson_led_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    dir_t             dir_q;
    logic             dir_en_r;
    logic             dir_flip;
    logic             cnt_en;
    logic             tick;
    logic             step_q;
    logic             led_legal;
    logic [LED_W-1:0] led_q, led_d;

    tick_gen #(
        .TICK_CNT (TICK_CNT),
        .CNT_W    (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (cnt_en),
        .tick  (tick)
    );

    // Any level change on the direction key since last cycle is one reversal request.
    assign dir_flip = bus.dir_en ^ dir_en_r;

    // A Johnson code has at most one 0/1 boundary between adjacent bits; anything else is corrupt.
    assign led_legal = $countones(led_q[LED_W-2:0] ^ led_q[LED_W-1:1]) <= 1;

    // Next FSM state and prescaler enable; counting happens only while running with run_en still high.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_en  = 1'b0;
        case (state_q)
            S_IDLE:  if (bus.run_en) state_d = S_RUN;
            S_RUN: begin
                if (bus.run_en) cnt_en  = 1'b1;
                else            state_d = S_PAUSE;
            end
            S_PAUSE: if (bus.run_en) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // Next pattern: shift in the current direction, or clear a corrupt code back to all-zeros.
    always_comb begin
        led_d = led_q;
        if (!led_legal)
            led_d = '0;
        else if (dir_q == DIR_LEFT)
            led_d = {led_q[LED_W-2:0], ~led_q[LED_W-1]};
        else
            led_d = {~led_q[0], led_q[LED_W-1:1]};
    end

    // State, direction, edge-detect history, step pulse and pattern register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            dir_q    <= DIR_LEFT;
            dir_en_r <= 1'b0;
            step_q   <= 1'b0;
            led_q    <= '0;
        end else begin
            state_q  <= state_d;
            dir_en_r <= bus.dir_en;
            step_q   <= tick;
            // A step on the same edge as a flip still uses the old direction.
            if (dir_flip) dir_q <= (dir_q == DIR_LEFT) ? DIR_RIGHT : DIR_LEFT;
            if (tick)     led_q <= led_d;
        end
    end

    assign bus.led       = led_q;
    assign bus.step_tick = step_q;
    assign bus.dir_o     = dir_q;
endmodule

// File: tb/tb_johnson_led_ctrl.sv
// Self-checking bench for johnson_led_ctrl (LED_W=4, TICK_CNT=4): directed key scenarios,
// a sequence-table reference model compared every cycle, plus literal expectations.
module tb_johnson_led_ctrl;
    localparam int W        = 4;
    localparam int TICK_CNT = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    johnson_led_ctrl_if #(.LED_W(W)) bus ();

    johnson_led_ctrl #(
        .LED_W    (W),
        .TICK_CNT (TICK_CNT),
        .CNT_W    (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: the legal codes listed in left-shift order; a step moves one place along
    // the list (left = forward, right = backward), anything off the list goes to zero.
    function automatic logic [W-1:0] next_code(input logic [W-1:0] cur, input logic dir);
        logic [W-1:0] seq [2*W];
        int idx = -1;
        for (int k = 0; k < 2*W; k++) begin
            if (k <= W) seq[k] = W'((32'd1 << k) - 32'd1);
            else        seq[k] = W'(~((32'd1 << (k - W)) - 32'd1));
        end
        for (int k = 0; k < 2*W; k++)
            if (seq[k] == cur) idx = k;
        if (idx < 0) return '0;
        return dir ? seq[(idx + 2*W - 1) % (2*W)] : seq[(idx + 1) % (2*W)];
    endfunction

    // Model state: a step happens after TICK_CNT cycles in which run_en was high in that
    // cycle and the one before; dir toggles on every dir_en level change.
    logic [W-1:0] m_led;
    logic         m_step, m_dir, m_dir_prev, m_active;
    int           m_cnt;
    int           inject_cnt, inject_seen;
    logic [W-1:0] inject_led;

    initial begin
        inject_cnt = 0;
        inject_led = '0;
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_led = '0; m_step = 0; m_dir = 0; m_dir_prev = 0; m_active = 0;
            m_cnt = 0; inject_seen = inject_cnt;
        end else begin
            if (inject_cnt != inject_seen) begin
                m_led       = inject_led;
                inject_seen = inject_cnt;
            end
            m_step = 0;
            if (m_active && bus.run_en) begin
                m_cnt++;
                if (m_cnt == TICK_CNT) begin
                    m_cnt  = 0;
                    m_step = 1;
                    m_led  = next_code(m_led, m_dir);
                end
            end
            m_active = bus.run_en;
            if (bus.dir_en != m_dir_prev) m_dir = ~m_dir;
            m_dir_prev = bus.dir_en;
        end
    end

    // Cycle-by-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        check("cmp led", bus.led, m_led);
        check("cmp step_tick", bus.step_tick, m_step);
        check("cmp dir_o", bus.dir_o, m_dir);
    end

    task automatic goto_cycle(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_step(input string name);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.step_tick && n < 64);
        check({name, " step seen"}, bus.step_tick, 1);
    endtask

    task automatic wait_led(input string name, input logic [W-1:0] val);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(bus.step_tick && bus.led == val) && n < 200);
        check(name, bus.led, val);
    endtask

    logic [W-1:0] t1_exp [4] = '{4'b0011, 4'b0111, 4'b1111, 4'b1110};

    initial begin
        int s, p, r, ticks, nonzero;
        rst_n      = 1'b0;
        bus.run_en = 1'b0;
        bus.dir_en = 1'b0;
        repeat (2) @(negedge clk);
        check("reset led", bus.led, 0);
        check("reset step_tick", bus.step_tick, 0);
        check("reset dir_o", bus.dir_o, 0);
        rst_n = 1'b1;

        // 1: start at cycle 10, first step at cycle 15, then every 4 cycles.
        goto_cycle(10);
        bus.run_en = 1'b1;
        goto_cycle(14);
        check("t1 no step before latency", bus.step_tick, 0);
        goto_cycle(15);
        check("t1 first step_tick", bus.step_tick, 1);
        check("t1 first led", bus.led, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            goto_cycle(19 + 4*k);
            check("t1 step_tick", bus.step_tick, 1);
            check("t1 led", bus.led, t1_exp[k]);
        end

        // 2: pause one cycle into the count at 0111; resume needs only the remaining 3 counts.
        wait_led("t2 reach 0111", 4'b0111);
        s = cyc;
        goto_cycle(s + 1);
        bus.run_en = 1'b0;
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.step_tick) ticks++;
        end
        check("t2 ticks while paused", ticks, 0);
        check("t2 led held", bus.led, 4'b0111);
        p = cyc;
        bus.run_en = 1'b1;
        goto_cycle(p + 3);
        check("t2 no early step", bus.step_tick, 0);
        check("t2 led before resume step", bus.led, 4'b0111);
        goto_cycle(p + 4);
        check("t2 resume step_tick", bus.step_tick, 1);
        check("t2 resume led", bus.led, 4'b1111);

        // 3: reverse at 0011.
        wait_led("t3 reach 0011", 4'b0011);
        bus.dir_en = 1'b1;
        @(negedge clk);
        check("t3 dir_o next clk", bus.dir_o, 1);
        wait_step("t3 a");
        check("t3 led a", bus.led, 4'b0001);
        wait_step("t3 b");
        check("t3 led b", bus.led, 4'b0000);
        wait_step("t3 c");
        check("t3 led c", bus.led, 4'b1000);

        // 4: flip in the cycle the prescaler wraps: that step is still right, the next is left.
        s = cyc;
        goto_cycle(s + 3);
        bus.dir_en = 1'b0;
        goto_cycle(s + 4);
        check("t4 step_tick", bus.step_tick, 1);
        check("t4 old-dir led", bus.led, 4'b1100);
        check("t4 dir_o", bus.dir_o, 0);
        goto_cycle(s + 8);
        check("t4 new-dir led", bus.led, 4'b1000);

        // 5: corrupt the register; next step clears it, then the left sequence resumes.
        goto_cycle(s + 9);
        #2;
        force dut.led_q = 4'b0101;
        inject_led = 4'b0101;
        inject_cnt++;
        #1;
        release dut.led_q;
        wait_step("t5 a");
        check("t5 recover led", bus.led, 4'b0000);
        wait_step("t5 b");
        check("t5 led b", bus.led, 4'b0001);
        wait_step("t5 c");
        check("t5 led c", bus.led, 4'b0011);

        // 6: reach 1110 with dir freshly right, then reset mid-cycle.
        wait_led("t6 reach 1111", 4'b1111);
        s = cyc;
        goto_cycle(s + 3);
        bus.dir_en = 1'b1;
        goto_cycle(s + 4);
        check("t6 led 1110", bus.led, 4'b1110);
        check("t6 step before reset", bus.step_tick, 1);
        check("t6 dir before reset", bus.dir_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6 async led", bus.led, 0);
        check("t6 async dir_o", bus.dir_o, 0);
        check("t6 async step_tick", bus.step_tick, 0);
        bus.run_en = 1'b0;
        bus.dir_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ticks   = 0;
        nonzero = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.step_tick) ticks++;
            if (bus.led != '0) nonzero++;
        end
        check("t6 idle ticks", ticks, 0);
        check("t6 idle led nonzero cycles", nonzero, 0);
        r = cyc;
        bus.run_en = 1'b1;
        goto_cycle(r + 4);
        check("t6 restart no early step", bus.step_tick, 0);
        goto_cycle(r + 5);
        check("t6 restart step_tick", bus.step_tick, 1);
        check("t6 restart led", bus.led, 4'b0001);
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
